// File: rtl/self_attention_head_scatter.sv
// -----------------------------------------------------------------------------
// self_attention_head_scatter
//
// Splits one stream of embedding blocks (tokens x features) into NUM_HEADS
// per-head streams. Each block row along dim 0 is cut into NUM_HEADS contiguous
// groups of BLOCKS_PER_HEAD blocks. Group g of every row goes to head g.
//
// Ports
//   clk                  clock
//   rst                  synchronous, active-high reset
//   data_in              input block, BLK elements of DATA_PRECISION_0 bits
//   data_in_valid        input block valid
//   data_in_ready        input block accepted when valid & ready
//   split_head_out       per-head output block (one-entry register per head)
//   split_head_out_valid per-head valid
//   split_head_out_ready per-head ready
//   tensor_done          1-cycle pulse after the last block of a tensor is taken
//
// Handshake semantics (input and every output): a transfer happens on a rising
// clock edge where valid & ready are both 1. A source holding valid keeps its
// data stable until the transfer. Valid never depends on ready. data_in_ready
// depends only on the register of the currently addressed head and that head's
// ready, so a stalled head blocks only the input aimed at it.
// -----------------------------------------------------------------------------
module self_attention_head_scatter #(
    parameter int NUM_HEADS              = 4,
    parameter int DATA_TENSOR_SIZE_DIM_0 = 64,
    parameter int DATA_TENSOR_SIZE_DIM_1 = 32,
    parameter int DATA_PARALLELISM_DIM_0 = 4,
    parameter int DATA_PARALLELISM_DIM_1 = 4,
    parameter int DATA_PRECISION_0       = 16,
    parameter int DATA_PRECISION_1       = 3,
    localparam int BLK = DATA_PARALLELISM_DIM_0 * DATA_PARALLELISM_DIM_1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_PRECISION_0-1:0] data_in [BLK],
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic [DATA_PRECISION_0-1:0] split_head_out [NUM_HEADS][BLK],
    output logic [NUM_HEADS-1:0]        split_head_out_valid,
    input  logic [NUM_HEADS-1:0]        split_head_out_ready,
    output logic                        tensor_done
);

    localparam int DEPTH_DIM_0     = DATA_TENSOR_SIZE_DIM_0 / DATA_PARALLELISM_DIM_0;
    localparam int DEPTH_DIM_1     = DATA_TENSOR_SIZE_DIM_1 / DATA_PARALLELISM_DIM_1;
    localparam int BLOCKS_PER_HEAD = DEPTH_DIM_0 / NUM_HEADS;

    localparam int BW = (BLOCKS_PER_HEAD > 1) ? $clog2(BLOCKS_PER_HEAD) : 1;
    localparam int HW = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1;
    localparam int RW = (DEPTH_DIM_1 > 1) ? $clog2(DEPTH_DIM_1) : 1;

    localparam logic [BW-1:0] BLK_LAST  = BW'(BLOCKS_PER_HEAD - 1);
    localparam logic [HW-1:0] HEAD_LAST = HW'(NUM_HEADS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(DEPTH_DIM_1 - 1);

    // The fractional width is carried along untouched; it only has to make
    // sense relative to the total width.
    if ((DATA_TENSOR_SIZE_DIM_0 % DATA_PARALLELISM_DIM_0) != 0 ||
        (DATA_TENSOR_SIZE_DIM_1 % DATA_PARALLELISM_DIM_1) != 0 ||
        (DEPTH_DIM_0 % NUM_HEADS) != 0 ||
        (DATA_PRECISION_1 >= DATA_PRECISION_0)) begin : g_param_check
        $error("self_attention_head_scatter: illegal parameter combination");
    end

    logic [BW-1:0] blk_cnt;
    logic [HW-1:0] head_idx;
    logic [RW-1:0] row_cnt;

    logic [NUM_HEADS-1:0]        reg_valid;
    logic [DATA_PRECISION_0-1:0] reg_data [NUM_HEADS][BLK];

    logic sel_valid;
    logic sel_ready;
    logic accept;
    logic blk_last;
    logic head_last;
    logic row_last;

    // Mux out the addressed head's state with a compare loop so the select
    // stays well-formed for any NUM_HEADS, including 1.
    always_comb begin
        sel_valid = 1'b0;
        sel_ready = 1'b0;
        for (int h = 0; h < NUM_HEADS; h++) begin
            if (head_idx == HW'(h)) begin
                sel_valid = reg_valid[h];
                sel_ready = split_head_out_ready[h];
            end
        end
    end

    // A full register that is draining this cycle can take new data at once,
    // which keeps a steady stream at one block per cycle.
    assign data_in_ready = ~sel_valid | sel_ready;
    assign accept        = data_in_valid & data_in_ready;

    assign blk_last  = (blk_cnt == BLK_LAST);
    assign head_last = (head_idx == HEAD_LAST);
    assign row_last  = (row_cnt == ROW_LAST);

    // Position counters: blk within head group, head within row, row within tensor.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt     <= '0;
            head_idx    <= '0;
            row_cnt     <= '0;
            tensor_done <= 1'b0;
        end else begin
            tensor_done <= accept & blk_last & head_last & row_last;
            if (accept) begin
                if (blk_last) begin
                    blk_cnt <= '0;
                    if (head_last) begin
                        head_idx <= '0;
                        if (row_last) begin
                            row_cnt <= '0;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end else begin
                        head_idx <= head_idx + 1'b1;
                    end
                end else begin
                    blk_cnt <= blk_cnt + 1'b1;
                end
            end
        end
    end

    // Per-head valid: a load wins over a drain, so a simultaneous drain and
    // load keeps the head valid with the new block (no bubble).
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_valid <= '0;
        end else begin
            for (int h = 0; h < NUM_HEADS; h++) begin
                if (accept && (head_idx == HW'(h))) begin
                    reg_valid[h] <= 1'b1;
                end else if (split_head_out_ready[h]) begin
                    reg_valid[h] <= 1'b0;
                end
            end
        end
    end

    // Data registers need no reset; they are only observed while valid.
    always_ff @(posedge clk) begin
        for (int h = 0; h < NUM_HEADS; h++) begin
            if (accept && (head_idx == HW'(h))) begin
                reg_data[h] <= data_in;
            end
        end
    end

    assign split_head_out       = reg_data;
    assign split_head_out_valid = reg_valid;

endmodule

// File: tb/tb_self_attention_head_scatter.sv
// -----------------------------------------------------------------------------
// Bench for self_attention_head_scatter. Runs the block with a 16-token tensor
// (DEPTH_DIM_0 = 16, DEPTH_DIM_1 = 4, BLOCKS_PER_HEAD = 4, 64 blocks/tensor).
// A per-head expected queue models each head's pending output; a negedge
// compare process checks every output against it on every cycle.
// Element 0 of each block carries a tag used to pin the routing by hand.
// -----------------------------------------------------------------------------
module tb_self_attention_head_scatter;

    localparam int NH     = 4;
    localparam int D0     = 64;
    localparam int D1     = 16;
    localparam int PP0    = 4;
    localparam int PP1    = 4;
    localparam int W      = 16;
    localparam int BLK    = PP0 * PP1;
    localparam int DEPTH0 = D0 / PP0;
    localparam int DEPTH1 = D1 / PP1;
    localparam int BPH    = DEPTH0 / NH;
    localparam int TOTAL  = DEPTH0 * DEPTH1;
    localparam int PW     = W * BLK;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  din [BLK];
    logic          data_in_valid;
    logic          data_in_ready;
    logic [W-1:0]  sho [NH][BLK];
    logic [NH-1:0] sho_valid;
    logic [NH-1:0] out_rdy;
    logic          tensor_done;

    always #5 clk = ~clk;

    self_attention_head_scatter #(
        .NUM_HEADS(NH),
        .DATA_TENSOR_SIZE_DIM_0(D0),
        .DATA_TENSOR_SIZE_DIM_1(D1),
        .DATA_PARALLELISM_DIM_0(PP0),
        .DATA_PARALLELISM_DIM_1(PP1),
        .DATA_PRECISION_0(W),
        .DATA_PRECISION_1(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(din),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .split_head_out(sho),
        .split_head_out_valid(sho_valid),
        .split_head_out_ready(out_rdy),
        .tensor_done(tensor_done)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;

    logic [PW-1:0] exp_q [NH][$];
    int            rx_q  [NH][$];
    int            cnt      = 0;
    logic          exp_done = 1'b0;
    logic          mon_en   = 1'b0;
    int            done_cnt = 0;
    int            run1     = 0;
    int            max1     = 0;

    function automatic void chk(input string name, input logic [PW-1:0] got,
                                input logic [PW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endfunction

    function automatic logic [PW-1:0] pack_out(input int h);
        logic [PW-1:0] p;
        for (int i = 0; i < BLK; i++) p[i*W +: W] = sho[h][i];
        return p;
    endfunction

    function automatic logic [PW-1:0] pack_in();
        logic [PW-1:0] p;
        for (int i = 0; i < BLK; i++) p[i*W +: W] = din[i];
        return p;
    endfunction

    // Compare process: check outputs, then advance the model by whatever
    // handshakes happen at the coming rising edge.
    always @(negedge clk) begin
        int            tgt;
        logic [PW-1:0] tmp;
        tgt = (cnt % DEPTH0) / BPH;
        if (mon_en) begin
            chk("tensor_done", tensor_done, exp_done);
            for (int h = 0; h < NH; h++) begin
                chk($sformatf("valid_h%0d", h), sho_valid[h], exp_q[h].size() != 0);
                if (exp_q[h].size() != 0)
                    chk($sformatf("data_h%0d", h), pack_out(h), exp_q[h][0]);
            end
            chk("data_in_ready", data_in_ready, (exp_q[tgt].size() == 0) || out_rdy[tgt]);
        end
        if (tensor_done) done_cnt++;
        if (sho_valid[1] === 1'b1) run1++; else run1 = 0;
        if (run1 > max1) max1 = run1;
        if (rst) begin
            for (int h = 0; h < NH; h++) begin
                exp_q[h].delete();
                rx_q[h].delete();
            end
            cnt      = 0;
            exp_done = 1'b0;
            mon_en   = 1'b1;
            run1     = 0;
            max1     = 0;
        end else if (mon_en) begin
            exp_done = 1'b0;
            for (int h = 0; h < NH; h++) begin
                if (exp_q[h].size() != 0 && out_rdy[h]) begin
                    tmp = exp_q[h].pop_front();
                    rx_q[h].push_back(int'(tmp[W-1:0]));
                end
            end
            if (data_in_valid && data_in_ready) begin
                exp_q[tgt].push_back(pack_in());
                cnt++;
                if (cnt == TOTAL) begin
                    cnt      = 0;
                    exp_done = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers change inputs 1 time unit after a rising edge.
    task automatic reset_dut();
        @(posedge clk); #1;
        rst           = 1'b1;
        data_in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input int tag, output int waits);
        logic hs;
        int   t;
        t  = tag;
        hs = 1'b0;
        din[0] = t[W-1:0];
        for (int i = 1; i < BLK; i++) din[i] = W'($urandom);
        data_in_valid = 1'b1;
        waits = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            hs = data_in_ready;
            @(posedge clk); #1;
            if (hs) break;
            waits++;
        end
        chk("send_timeout", hs, 1'b1);
        data_in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int ws;
        int d0;
        logic stop;
        rst           = 1'b1;
        data_in_valid = 1'b0;
        out_rdy       = '1;
        for (int i = 0; i < BLK; i++) din[i] = '0;
        idle(3);
        rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_valid", sho_valid, '0);
        chk("rst_done", tensor_done, 1'b0);
        chk("rst_ready", data_in_ready, 1'b1);
        idle(1);

        // 1 + 4: full tensor at full rate
        reset_dut();
        d0 = done_cnt;
        ws = 0;
        for (int k = 0; k < TOTAL; k++) begin
            send(k, w);
            ws += w;
        end
        @(negedge clk);
        chk("t1_done_pulse", tensor_done, 1'b1);
        idle(3);
        chk("t1_stall_cycles", ws, 0);
        chk("t1_done_count", done_cnt - d0, 1);
        chk("t4_head1_run", max1, 4);
        for (int h = 0; h < NH; h++) begin
            chk($sformatf("t1_rx_size_h%0d", h), rx_q[h].size(), 16);
            for (int r = 0; r < DEPTH1; r++)
                for (int i = 0; i < BPH; i++)
                    chk($sformatf("t1_rx_h%0d_r%0d_i%0d", h, r, i),
                        rx_q[h][BPH*r+i], 4*h + i + 16*r);
        end

        // 2: head 0 stalled
        reset_dut();
        out_rdy = 4'b1110;
        send(0, w);
        chk("t2_blk0_wait", w, 0);
        fork
            send(1, w);
            begin
                repeat (3) @(negedge clk);
                chk("t2_h0_valid", sho_valid[0], 1'b1);
                chk("t2_h0_tag", sho[0][0], 0);
                chk("t2_in_stalled", data_in_ready, 1'b0);
                repeat (3) @(posedge clk);
                #1 out_rdy[0] = 1'b1;
            end
        join
        chk("t2_blk1_wait", w, 5);
        idle(3);

        // 3: head 2 stalled after being filled
        reset_dut();
        for (int k = 0; k < 12; k++) send(k, w);
        out_rdy[2] = 1'b0;
        ws = 0;
        for (int k = 12; k < 24; k++) begin
            send(k, w);
            ws += w;
        end
        chk("t3_no_stall", ws, 0);
        fork
            send(24, w);
            begin
                repeat (4) @(posedge clk);
                #1 out_rdy[2] = 1'b1;
            end
        join
        chk("t3_stall_at_h2", w, 4);
        idle(3);

        // 5: reset mid-tensor
        reset_dut();
        for (int k = 0; k < 37; k++) send(k, w);
        reset_dut();
        @(negedge clk);
        chk("t5_valid_cleared", sho_valid, '0);
        idle(1);
        d0 = done_cnt;
        for (int k = 0; k < TOTAL - 1; k++) send(100 + k, w);
        chk("t5_no_early_done", done_cnt - d0, 0);
        send(100 + TOTAL - 1, w);
        @(negedge clk);
        chk("t5_done_pulse", tensor_done, 1'b1);
        idle(3);
        chk("t5_first_on_h0", rx_q[0][0], 100);

        // 6: random valid/ready over 3 tensors
        reset_dut();
        d0   = done_cnt;
        stop = 1'b0;
        fork
            begin
                for (int k = 0; k < 3 * TOTAL; k++) begin
                    idle($urandom_range(0, 1));
                    send(1000 + k, w);
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk); #1;
                    if (!stop) out_rdy = NH'($urandom);
                end
            end
        join
        out_rdy = '1;
        idle(4);
        chk("t6_drained", sho_valid, '0);
        chk("t6_done_count", done_cnt - d0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
